// File: rtl/simple_pipeline_pkg.sv
// Shared constants and state type for the multiply-add pipeline feeder.
package simple_pipeline_pkg;

    localparam int NUM_INPUTS   = 8;
    localparam int PIPE_LATENCY = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/simple_pipeline_credit_counter.sv
// Tracks vectors in flight; a return may fund an issue on the same edge.
module simple_pipeline_credit_counter #(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic          credit_return,
    output logic [CW-1:0] count,
    output logic          has_credit
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    assign has_credit = (count != '0) || credit_return;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= MAX_CNT;
        end else if (credit_return && !issue) begin
            if (count != MAX_CNT)
                count <= count + CW'(1);
        end else if (issue && !credit_return) begin
            count <= count - CW'(1);
        end
    end

`ifndef SYNTHESIS
    // A return with every credit already home means the consumer miscounted.
    credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(credit_return && (count == MAX_CNT)));
`endif

endmodule

// File: rtl/simple_pipeline_feeder.sv
// Packs 8 stream words into one vector and issues it when a credit is available.
// Optional partial-vector flush: SIMPLE_PIPELINE_FEEDER_PARTIAL_FLUSH_EN.
//
// state | meaning
// FILL  | accepting words into the buffer; issues on completion if credit allows
// HOLD  | complete vector buffered, waiting for a credit; stream stalled
module simple_pipeline_feeder
    import simple_pipeline_pkg::*;
#(
    parameter  int WIDTH           = 16,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             credit_return,
    input  logic             flush,
    output logic [WIDTH-1:0] out [NUM_INPUTS],
    output logic             valid_out,
    output logic [CW-1:0]    credits_avail
);

    localparam int              IDXW     = $clog2(NUM_INPUTS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

    feeder_state_t   state;
    logic [IDXW-1:0] idx;
    logic [WIDTH-1:0] fill_buf [NUM_INPUTS];
    logic [WIDTH-1:0] vec_next [NUM_INPUTS];

    logic accept;
    logic flush_go;
    logic complete;
    logic has_credit;
    logic issue;

    assign accept   = in_valid && (state == FILL);
    assign complete = (accept && (idx == LAST_IDX)) || flush_go;
    assign issue    = has_credit && (((state == FILL) && complete) || (state == HOLD));

`ifdef SIMPLE_PIPELINE_FEEDER_PARTIAL_FLUSH_EN
    assign flush_go = (state == FILL) && flush && !in_valid && (idx != '0);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_go     = 1'b0;
`endif

    // Slots at or above idx are zero so a flushed vector is padded for free.
    always_comb begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
            vec_next[k] = '0;
            if (accept && (IDXW'(k) == idx))
                vec_next[k] = in_data;
            else if (IDXW'(k) < idx)
                vec_next[k] = fill_buf[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            in_ready  <= 1'b1;
            valid_out <= 1'b0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                fill_buf[k] <= '0;
                out[k]      <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            case (state)
                FILL: begin
                    if (complete) begin
                        idx <= '0;
                        if (has_credit) begin
                            out       <= vec_next;
                            valid_out <= 1'b1;
                        end else begin
                            fill_buf <= vec_next;
                            state    <= HOLD;
                            in_ready <= 1'b0;
                        end
                    end else if (accept) begin
                        fill_buf[idx] <= in_data;
                        idx           <= idx + IDXW'(1);
                    end
                end
                HOLD: begin
                    if (has_credit) begin
                        out       <= fill_buf;
                        valid_out <= 1'b1;
                        state     <= FILL;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    simple_pipeline_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .credit_return(credit_return),
        .count        (credits_avail),
        .has_credit   (has_credit)
    );

endmodule

// File: tb/tb_simple_pipeline_feeder.sv
// Scoreboard bench for simple_pipeline_feeder; honours SIMPLE_PIPELINE_FEEDER_PARTIAL_FLUSH_EN.
module tb_simple_pipeline_feeder;

    localparam int WIDTH = 16;
    localparam int NV    = 8;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             credit_return = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] out [NV];
    logic             valid_out;
    logic [CW-1:0]    credits_avail;

    simple_pipeline_feeder #(.WIDTH(WIDTH), .MAX_OUTSTANDING(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .credit_return(credit_return),
        .flush        (flush),
        .out          (out),
        .valid_out    (valid_out),
        .credits_avail(credits_avail)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_words(input logic [WIDTH-1:0] q [$]);
        logic [127:0] p = '0;
        for (int i = 0; i < q.size() && i < NV; i++) p[i*WIDTH +: WIDTH] = q[i];
        return p;
    endfunction

    function automatic logic [127:0] pack_out();
        logic [127:0] p;
        for (int i = 0; i < NV; i++) p[i*WIDTH +: WIDTH] = out[i];
        return p;
    endfunction

    function automatic logic [127:0] seq_vec(input int first);
        logic [127:0] p;
        for (int i = 0; i < NV; i++) p[i*WIDTH +: WIDTH] = WIDTH'(first + i);
        return p;
    endfunction

    // Scoreboard: words accepted at each edge build expected vectors.
    logic [WIDTH-1:0] cur [$];
    logic [127:0]     exp_q [$];
    int               cyc = 0;
    int               vcount = 0;
    int               pulse_cyc [0:255];
    logic             prev_v = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.delete();
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            cur.push_back(in_data);
            if (cur.size() == NV) begin
                exp_q.push_back(pack_words(cur));
                cur.delete();
            end
        end
`ifdef SIMPLE_PIPELINE_FEEDER_PARTIAL_FLUSH_EN
        else if (in_ready && flush && cur.size() > 0) begin
            exp_q.push_back(pack_words(cur));
            cur.delete();
        end
`endif
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                logic [127:0] e;
                check_val("no_back_to_back", prev_v, 1'b0);
                check_val("sb_vec_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("sb_vec_data", pack_out(), e);
                end
                if (vcount < 256) pulse_cyc[vcount] = cyc;
                vcount++;
            end
            prev_v = valid_out;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid      = 1'b0;
        credit_return = 1'b0;
        flush         = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic stream(input int first, input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_data = WIDTH'(first + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int v0;
        int sent;
        logic rdy;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int sent;
        logic rdy;

        step();
        step();
        rst = 1'b0;
        step();

        // Reset values
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_valid_out", valid_out, 1'b0);
        check_val("rst_credits", credits_avail, 3'd4);
        check_val("rst_out_zero", pack_out(), '0);

        // Single vector 1..8, pulse the cycle after the 8th word
        in_valid = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            in_data = WIDTH'(w);
            step();
            if (w == 7) check_val("t1_no_early_pulse", valid_out, 1'b0);
        end
        in_valid = 1'b0;
        check_val("t1_valid", valid_out, 1'b1);
        check_val("t1_credits", credits_avail, 3'd3);
        check_val("t1_out", pack_out(), seq_vec(1));
        step();
        check_val("t1_single_pulse", valid_out, 1'b0);
        check_val("t1_out_holds", pack_out(), seq_vec(1));

        // 64-word stream with credit starvation and HOLD
        do_reset();
        v0 = vcount;
        stream(100, 40);
        check_val("t2_four_issued", vcount - v0, 4);
        check_val("t2_hold_not_ready", in_ready, 1'b0);
        check_val("t2_credits_zero", credits_avail, 3'd0);
        for (int k = 1; k < 4; k++)
            check_val("t2_spacing", pulse_cyc[v0 + k] - pulse_cyc[v0 + k - 1], 8);
        repeat (3) step();
        check_val("t2_hold_waits", vcount - v0, 4);
        check_val("t2_still_stalled", in_ready, 1'b0);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check_val("t2_release_valid", valid_out, 1'b1);
        check_val("t2_release_ready", in_ready, 1'b1);
        check_val("t2_release_credits", credits_avail, 3'd0);
        credit_return = 1'b1;
        repeat (4) step();
        credit_return = 1'b0;
        check_val("t2_refilled", credits_avail, 3'd4);
        stream(140, 24);
        step();
        check_val("t2_total_vectors", vcount - v0, 8);
        check_val("t2_final_credits", credits_avail, 3'd1);
        check_val("t2_sb_empty", exp_q.size(), 0);

        // Same-edge credit return rescues an out-of-credit completion
        do_reset();
        stream(300, 32);
        step();
        check_val("t3_credits_zero", credits_avail, 3'd0);
        v0 = vcount;
        stream(400, 7);
        in_valid = 1'b1;
        in_data = WIDTH'(407);
        credit_return = 1'b1;
        step();
        in_valid = 1'b0;
        credit_return = 1'b0;
        check_val("t3_valid", valid_out, 1'b1);
        check_val("t3_credits_stay", credits_avail, 3'd0);
        check_val("t3_ready", in_ready, 1'b1);
        check_val("t3_out", pack_out(), seq_vec(400));

        // Random in_valid gaps
        do_reset();
        v0 = vcount;
        sent = 0;
        for (int c = 0; c < 300 && sent < 16; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = WIDTH'(500 + sent);
            rdy = in_ready;
            step();
            if (in_valid && rdy) sent++;
        end
        in_valid = 1'b0;
        step();
        check_val("t4_words_sent", sent, 16);
        check_val("t4_two_vectors", vcount - v0, 2);
        check_val("t4_credits", credits_avail, 3'd2);
        check_val("t4_sb_empty", exp_q.size(), 0);

        // Reset mid-fill discards the partial vector
        do_reset();
        stream(1, 8);
        stream(20, 5);
        step();
        check_val("t5_credits_before", credits_avail, 3'd3);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        check_val("t5_credits_after", credits_avail, 3'd4);
        check_val("t5_ready_after", in_ready, 1'b1);
        stream(9, 8);
        check_val("t5_valid", valid_out, 1'b1);
        check_val("t5_out", pack_out(), seq_vec(9));
        step();

        // Partial flush
        do_reset();
        v0 = vcount;
        stream(2, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef SIMPLE_PIPELINE_FEEDER_PARTIAL_FLUSH_EN
        check_val("t6_flush_valid", valid_out, 1'b1);
        check_val("t6_flush_out", pack_out(), 128'h0004_0003_0002);
        check_val("t6_flush_credits", credits_avail, 3'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("t6_flush_empty_ignored", valid_out, 1'b0);
        check_val("t6_vectors", vcount - v0, 1);
`else
        check_val("t6_no_flush_pulse", valid_out, 1'b0);
        check_val("t6_credits_kept", credits_avail, 3'd4);
        repeat (2) step();
        check_val("t6_vectors", vcount - v0, 0);
`endif
        step();
        check_val("end_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
